// File: rtl/race_game_if.sv
// race_game_if: button/frame inputs and renderer-facing outputs of the race game controller
interface race_game_if #(parameter int SCROLL_W = 10);
  logic                left;
  logic                right;
  logic                frame_tick;
  logic                collision;
  logic [1:0]          car_lane;
  logic [SCROLL_W-1:0] scroll_y;
  logic [3:0]          speed;
  logic [15:0]         score;
  logic [1:0]          state;
  logic                flash;
  modport master (
    output left, right, frame_tick, collision,
    input  car_lane, scroll_y, speed, score, state, flash
  );
  modport slave (
    input  left, right, frame_tick, collision,
    output car_lane, scroll_y, speed, score, state, flash
  );
endinterface

// File: rtl/race_game_controller.sv
// race_game_controller: debounced buttons + IDLE/PLAY/CRASH/OVER frame sequencer; RACE_PAUSE_EN adds a both-button pause in PLAY
module race_game_controller #(
  parameter int LANES            = 3,
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int SPEED_INIT       = 1,
  parameter int SPEED_MAX        = 8,
  parameter int FRAMES_PER_LEVEL = 600,
  parameter int CRASH_FRAMES     = 120,
  parameter int SCROLL_W         = 10
) (
  input  logic        clk50mhz,
  input  logic        reset,
  race_game_if.slave  bus
);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW  = $clog2(FRAMES_PER_LEVEL + 1);
  localparam int CRW = ($clog2(CRASH_FRAMES + 1) < 3) ? 3 : $clog2(CRASH_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, PLAY, CRASH, OVER} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             s1_q, s2_q, prev_q, db_q, db_d, pend_q, pend_d, press, eff;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [1:0]             lane_q, lane_d;
  logic [SCROLL_W-1:0]    scroll_q, scroll_d;
  logic [3:0]             speed_q, speed_d;
  logic [15:0]            score_q, score_d;
  logic [FW-1:0]          frame_q, frame_d;
  logic [CRW-1:0]         crash_q, crash_d;
  logic                   flash_q, flash_d;
  logic                   run;
  logic [16:0]            sum;
`ifdef RACE_PAUSE_EN
  logic                   pause_q, pause_d;
`endif
  assign bus.car_lane = lane_q;
  assign bus.scroll_y = scroll_q;
  assign bus.speed    = speed_q;
  assign bus.score    = score_q;
  assign bus.state    = state_q;
  assign bus.flash    = flash_q;
  // Debounce: counter restarts whenever the synced level moves, level accepted after DEBOUNCE_CYCLES stable cycles
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (s2_q[b] != prev_q[b]) cnt_d[b] = '0;
      else if (s2_q[b] != db_q[b]) begin
        if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[b]  = s2_q[b];
          cnt_d[b] = '0;
        end else cnt_d[b] = cnt_q[b] + 1'b1;
      end else cnt_d[b] = '0;
    end
    press = db_d & ~db_q;
  end
  // Game FSM and frame-rate updates; a press arriving with frame_tick is folded into that tick
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    scroll_d = scroll_q;
    speed_d  = speed_q;
    score_d  = score_q;
    frame_d  = frame_q;
    crash_d  = crash_q;
    flash_d  = flash_q;
    eff      = pend_q | press;
    pend_d   = (bus.frame_tick || state_q != PLAY) ? 2'b00 : eff;
    sum      = {1'b0, score_q} + 17'(speed_q);
    run      = 1'b1;
`ifdef RACE_PAUSE_EN
    pause_d  = pause_q;
    if (state_q == PLAY && bus.frame_tick && eff == 2'b11) pause_d = ~pause_q;
    run      = !pause_q && eff != 2'b11;
`endif
    case (state_q)
      IDLE: if (|press) begin
        state_d  = PLAY;
        lane_d   = 2'(LANES / 2);
        scroll_d = '0;
        speed_d  = 4'(SPEED_INIT);
        score_d  = '0;
        frame_d  = '0;
      end
      PLAY: if (bus.frame_tick && run) begin
        if (bus.collision) begin
          state_d = CRASH;
          crash_d = '0;
          flash_d = 1'b0;
        end else begin
          if (eff == 2'b01 && lane_q != 2'd0) lane_d = lane_q - 2'd1;
          if (eff == 2'b10 && lane_q != 2'(LANES - 1)) lane_d = lane_q + 2'd1;
          scroll_d = scroll_q + SCROLL_W'(speed_q);
          score_d  = sum[16] ? 16'hFFFF : sum[15:0];
          if (frame_q == FW'(FRAMES_PER_LEVEL - 1)) begin
            frame_d = '0;
            speed_d = (speed_q >= 4'(SPEED_MAX)) ? speed_q : speed_q + 4'd1;
          end else frame_d = frame_q + 1'b1;
        end
      end
      CRASH: if (bus.frame_tick) begin
        if (crash_q == CRW'(CRASH_FRAMES - 1)) begin
          state_d = OVER;
          flash_d = 1'b0;
        end else begin
          crash_d = crash_q + 1'b1;
          flash_d = (crash_q[2:0] == 3'd7) ? ~flash_q : flash_q;
        end
      end
      default: if (|press) begin
        state_d  = IDLE;
        lane_d   = 2'(LANES / 2);
        scroll_d = '0;
        speed_d  = 4'(SPEED_INIT);
        frame_d  = '0;
      end
    endcase
`ifdef RACE_PAUSE_EN
    if (state_d != PLAY) pause_d = 1'b0;
`endif
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk50mhz or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      db_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      state_q  <= IDLE;
      lane_q   <= 2'(LANES / 2);
      scroll_q <= '0;
      speed_q  <= 4'(SPEED_INIT);
      score_q  <= '0;
      frame_q  <= '0;
      crash_q  <= '0;
      flash_q  <= 1'b0;
`ifdef RACE_PAUSE_EN
      pause_q  <= 1'b0;
`endif
    end else begin
      s1_q     <= {bus.right, bus.left};
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      lane_q   <= lane_d;
      scroll_q <= scroll_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      frame_q  <= frame_d;
      crash_q  <= crash_d;
      flash_q  <= flash_d;
`ifdef RACE_PAUSE_EN
      pause_q  <= pause_d;
`endif
    end
  end
endmodule

// File: tb/tb_race_game_controller.sv
// tb_race_game_controller: directed vector table plus hand sequences for the race game controller
module tb_race_game_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  race_game_if #(.SCROLL_W(10)) bus ();
  race_game_controller #(
    .LANES(3), .DEBOUNCE_CYCLES(4), .SPEED_INIT(1), .SPEED_MAX(8),
    .FRAMES_PER_LEVEL(4), .CRASH_FRAMES(3), .SCROLL_W(10)
  ) dut (
    .clk50mhz(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic pl, pr, col;
    int   lane, scroll, speed, score, state;
  } vec_t;
  vec_t vecs[11];
  int   m_scroll, m_speed, m_score, m_cnt;
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic press(input int b);
    if (b == 0) bus.left = 1'b1; else bus.right = 1'b1;
    repeat (12) @(negedge clk);
    bus.left = 1'b0;
    bus.right = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic tick(input logic col);
    bus.collision = col;
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    bus.collision = 1'b0;
    @(negedge clk);
  endtask
  task automatic chk_all(input string n, input int lane, input int scroll, input int speed, input int score, input int state);
    chk({n, " lane"}, int'(bus.car_lane), lane);
    chk({n, " scroll"}, int'(bus.scroll_y), scroll);
    chk({n, " speed"}, int'(bus.speed), speed);
    chk({n, " score"}, int'(bus.score), score);
    chk({n, " state"}, int'(bus.state), state);
  endtask
  initial begin
    vecs[0]  = '{0, 0, 0, 1, 1,  1, 1,  1};
    vecs[1]  = '{0, 1, 0, 2, 2,  1, 2,  1};
    vecs[2]  = '{0, 1, 0, 2, 3,  1, 3,  1};
    vecs[3]  = '{0, 1, 0, 2, 4,  2, 4,  1};
    vecs[4]  = '{1, 0, 0, 1, 6,  2, 6,  1};
    vecs[5]  = '{1, 0, 0, 0, 8,  2, 8,  1};
    vecs[6]  = '{1, 0, 0, 0, 10, 2, 10, 1};
    vecs[7]  = '{0, 0, 0, 0, 12, 3, 12, 1};
    vecs[8]  = '{1, 1, 0, 0, 15, 3, 15, 1};
    vecs[9]  = '{0, 1, 0, 1, 18, 3, 18, 1};
    vecs[10] = '{0, 1, 1, 1, 18, 3, 18, 2};
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.frame_tick = 1'b0;
    bus.collision = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 1, 0, 1, 0, 0);
    chk("reset flash", int'(bus.flash), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus.left = 1'b1;
    @(negedge clk);
    bus.left = 1'b0;
    @(negedge clk);
    bus.left = 1'b1;
    repeat (10) @(negedge clk);
    bus.left = 1'b0;
    repeat (12) @(negedge clk);
    chk_all("start", 1, 0, 1, 0, 1);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].pl) press(0);
      if (vecs[i].pr) press(1);
      tick(vecs[i].col);
      chk_all($sformatf("vec%0d", i), vecs[i].lane, vecs[i].scroll, vecs[i].speed, vecs[i].score, vecs[i].state);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      chk($sformatf("crash%0d state", i), int'(bus.state), 2);
      chk($sformatf("crash%0d flash", i), int'(bus.flash), 0);
    end
    tick(1'b0);
    chk_all("over", 1, 18, 3, 18, 3);
    chk("over flash", int'(bus.flash), 0);
    press(0);
    chk_all("idle again", 1, 0, 1, 18, 0);
    press(1);
    chk_all("replay", 1, 0, 1, 0, 1);
    m_scroll = 0;
    m_speed = 1;
    m_score = 0;
    m_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1'b0);
      m_scroll = (m_scroll + m_speed) % 1024;
      m_score += m_speed;
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_speed < 8) m_speed++;
      end else m_cnt++;
      chk($sformatf("run%0d scroll", i), int'(bus.scroll_y), m_scroll);
      chk($sformatf("run%0d speed", i), int'(bus.speed), m_speed);
      chk($sformatf("run%0d score", i), int'(bus.score), m_score);
    end
    tick(1'b1);
    chk("mid crash state", int'(bus.state), 2);
    #2 reset = 1'b0;
    #1;
    chk_all("async reset", 1, 0, 1, 0, 0);
    chk("async reset flash", int'(bus.flash), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
